// File: rtl/hazard_control_unit.sv
// hazard_control_unit: PC / IF/ID / ID/EX enable and flush control for load-use stalls and EX redirects.
// Optional macro HAZARD_PERF_EN adds stall-cycle and redirect-flush performance counters.
`default_nettype none

module hazard_control_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Freeze,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             IF_ID_UsesRt,
    input  logic [4:0]       ID_EX_Rt,
    input  logic             ID_EX_MemRead,
    input  logic             BranchTaken_EX,
    input  logic             J_EX,
    input  logic             JAL_EX,
    input  logic             JR_EX,
    output logic             PCWrite,
    output logic             Enable_IF_ID,
    output logic             Enable_ID_EX,
    output logic             Flush_IF_ID,
    output logic             Flush_ID_EX,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [3:0] c_STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] stall_left_q, stall_left_d;
    logic       w_lu;
    logic       w_rd;

    assign w_lu = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                  ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
    assign w_rd = BranchTaken_EX | J_EX | JAL_EX | JR_EX;

    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        PCWrite      = 1'b0;
        Enable_IF_ID = 1'b0;
        Enable_ID_EX = 1'b0;
        Flush_IF_ID  = 1'b0;
        Flush_ID_EX  = 1'b0;
        if (reset || Freeze) begin
            // everything held and all enables low
        end else if (w_rd) begin
            PCWrite      = 1'b1;
            Enable_IF_ID = 1'b1;
            Enable_ID_EX = 1'b1;
            Flush_IF_ID  = 1'b1;
            Flush_ID_EX  = 1'b1;
            state_d      = RUN;
            stall_left_d = 4'd0;
        end else if (state_q == STALL) begin
            Enable_ID_EX = 1'b1;
            Flush_ID_EX  = 1'b1;
            stall_left_d = stall_left_q - 4'd1;
            if (stall_left_q == 4'd1) begin
                state_d = RUN;
            end
        end else if (w_lu) begin
            Enable_ID_EX = 1'b1;
            Flush_ID_EX  = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_d      = STALL;
                stall_left_d = c_STALL_RELOAD;
            end
        end else begin
            PCWrite      = 1'b1;
            Enable_IF_ID = 1'b1;
            Enable_ID_EX = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            stall_left_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic             w_stall_inc;
    logic             w_flush_inc;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // A bubble cycle is any unfrozen, unredirected cycle spent in STALL or detecting LU in RUN.
    assign w_stall_inc = !reset && !Freeze && !w_rd && ((state_q == STALL) || w_lu);
    assign w_flush_inc = !reset && !Freeze && w_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (w_stall_inc) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (w_flush_inc) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

`default_nettype wire

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline hazard controller that drives the write enables and flush (bubble) controls of the PC, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards from ID/EX state against the instruction in IF/ID, and inserts bubbles for a configurable number of cycles.
- Squashes wrong-path instructions when a branch or jump resolves in EX.
- Honours a global freeze request from the memory side.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15).
- CNT_W, 32, width of the performance counters (used only with HAZARD_PERF_EN).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Freeze  input  1  memory busy; stall the whole front end.
- IF_ID_Rs  input  5  rs field of the instruction in ID.
- IF_ID_Rt  input  5  rt field of the instruction in ID.
- IF_ID_UsesRt  input  1  instruction in ID reads rt as a source.
- ID_EX_Rt  input  5  destination rt of the instruction in EX.
- ID_EX_MemRead  input  1  instruction in EX is a load.
- BranchTaken_EX  input  1  BEQ/BNE resolved taken in EX.
- J_EX  input  1  J in EX.
- JAL_EX  input  1  JAL in EX.
- JR_EX  input  1  JR in EX.
- PCWrite  output  1  PC load enable.
- Enable_IF_ID  output  1  IF/ID load enable.
- Enable_ID_EX  output  1  ID/EX load enable.
- Flush_IF_ID  output  1  IF/ID loads NOP.
- Flush_ID_EX  output  1  ID/EX loads a bubble (all control fields 0).
- StallCount  output  CNT_W  load-use bubble cycles inserted.
- FlushCount  output  CNT_W  redirect flush events.

Behaviour:
- Internal state: FSM {RUN, STALL} plus a 4-bit down-counter StallLeft. Outputs are Mealy: a function of state and current inputs.
- Reset, applied while reset=1 at a rising edge:
  - FSM goes to RUN, StallLeft=0, counters=0.
  - While reset=1, outputs are PCWrite=0, Enable_IF_ID=0, Enable_ID_EX=0, Flush_IF_ID=0, Flush_ID_EX=0.
  - Reset mid-stall aborts the stall with no residual bubbles.
- Signal definitions:
  - LU = ID_EX_MemRead && ID_EX_Rt!=0 && (ID_EX_Rt==IF_ID_Rs || (IF_ID_UsesRt && ID_EX_Rt==IF_ID_Rt)).
  - Register 0 never causes a hazard.
  - RD = BranchTaken_EX | J_EX | JAL_EX | JR_EX.
- Priority each cycle: Freeze > RD > LU/STALL > normal.
- Freeze=1, any state:
  - PCWrite=0, Enable_IF_ID=0, Enable_ID_EX=0, both flushes 0.
  - FSM, StallLeft and counters hold.
  - RD and LU are ignored this cycle and re-evaluated when Freeze drops, because the inputs are held.
- RD=1 (Freeze=0), any state:
  - PCWrite=1, Enable_IF_ID=1, Enable_ID_EX=1, Flush_IF_ID=1, Flush_ID_EX=1.
  - Next state RUN, StallLeft=0, FlushCount+1.
  - A pending load-use stall is discarded, since the dependent instruction is on the wrong path.
- RUN with LU=1 (no Freeze, no RD):
  - PCWrite=0, Enable_IF_ID=0, Enable_ID_EX=1, Flush_ID_EX=1, Flush_IF_ID=0.
  - StallCount+1.
  - If LOAD_STALL_CYCLES>1: next state STALL, StallLeft=LOAD_STALL_CYCLES-1. Otherwise stay in RUN.
- STALL (no Freeze, no RD):
  - Same outputs as the LU cycle; StallCount+1; StallLeft-1.
  - When StallLeft==1 at the edge, next state RUN.
  - LU is not re-evaluated in STALL.
- RUN with no event: PCWrite=1, Enable_IF_ID=1, Enable_ID_EX=1, flushes 0.
- Latency: hazard outputs respond combinationally in the same cycle the hazard inputs appear. State effects take hold at the next rising edge.
- Counters wrap modulo 2^CNT_W and never saturate.

Optional Feature:
- HAZARD_PERF_EN defined: StallCount and FlushCount are implemented as described.
- HAZARD_PERF_EN undefined: both ports are driven constant 0 and no counter flops are instantiated. All other behaviour is identical.

Test Plan:
- Reset: hold reset=1 for 2 cycles with LU=1 and RD=1 -> all five control outputs 0; after release, with no hazard, PCWrite=Enable_IF_ID=Enable_ID_EX=1 and flushes 0.
- Load-use, LOAD_STALL_CYCLES=1: ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 -> exactly 1 cycle of PCWrite=0, Enable_IF_ID=0, Flush_ID_EX=1; then with MemRead=0 normal flow resumes; StallCount=1.
- Zero register and unused rt: ID_EX_Rt=0 with IF_ID_Rs=0 -> no stall; ID_EX_Rt=9, IF_ID_Rt=9, IF_ID_UsesRt=0 -> no stall.
- LOAD_STALL_CYCLES=3: one LU event -> 3 consecutive bubble cycles; assert Freeze for 2 cycles during the second bubble -> bubbles still total 3, stall spans 5 cycles, StallCount=3.
- Redirect over stall: LU and JR_EX=1 in the same cycle -> Flush_IF_ID=1, Flush_ID_EX=1, PCWrite=1, FSM stays RUN, StallCount unchanged, FlushCount=1; BranchTaken_EX during STALL -> stall aborted the same cycle.
- Perf build: run 10 LU events and 4 RD events with HAZARD_PERF_EN defined -> StallCount=10, FlushCount=4; build without the macro -> both read 0.
